// File: rtl/mmc1_pkg.sv
// mmc1_pkg
//   Shared constants for the MMC1 serial loader and the mapper register file
//   that consumes its strobes.
//   - reg_sel_e      : target register encoding carried on reg_sel
//   - MMC1_RESET_BIT : CPU data bit that restarts the serial sequence
//   - MMC1_SHIFT_LEN : number of serial bits per register write
package mmc1_pkg;

   typedef enum logic [1:0] {
      REG_CTRL = 2'd0,
      REG_CHR0 = 2'd1,
      REG_CHR1 = 2'd2,
      REG_PRG  = 2'd3
   } reg_sel_e;

   localparam int MMC1_RESET_BIT = 7;
   localparam int MMC1_SHIFT_LEN = 5;

endpackage : mmc1_pkg

// File: rtl/mmc1_write_filter.sv
// mmc1_write_filter
//   Detects CPU write cycles to $8000-$FFFF and suppresses the second (and
//   any further) write of a run of back-to-back write cycles. This drops
//   the dummy write of read-modify-write instructions.
//   Ports:
//     m2        in  : CPU M2; state advances on its falling edge
//     rst_n     in  : asynchronous active-low reset
//     enable    in  : block enabled (MMC1 selected); low clears the history
//     romsel    in  : CPU /ROMSEL, low = $8000-$FFFF
//     cpu_rw_in in  : CPU R/W, low = write
//     accept    out : this cycle is a write that the loader must act on
module mmc1_write_filter (
   input  logic m2,
   input  logic rst_n,
   input  logic enable,
   input  logic romsel,
   input  logic cpu_rw_in,
   output logic accept
);

   logic wr_cyc;
   logic prev_wr_d;
   logic prev_wr_q;

   // With enable low wr_cyc is 0, so the history clears on the next edge.
   always_comb begin
      wr_cyc    = enable & ~cpu_rw_in & ~romsel;
      prev_wr_d = wr_cyc;
      accept    = wr_cyc & ~prev_wr_q;
   end

   always_ff @(negedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         prev_wr_q <= 1'b0;
      end else begin
         prev_wr_q <= prev_wr_d;
      end
   end

endmodule : mmc1_write_filter

// File: rtl/mmc1_serial_port.sv
// mmc1_serial_port
//   CPU-side serial loader for MMC1. Assembles five LSB-first bits (D0) from
//   accepted writes and emits a one-period register-write strobe, or a
//   control-reset strobe when an accepted write has D7 set.
//   Strobe protocol: reg_wr and ctrl_reset are registered single-period
//   pulses with no back-pressure; reg_sel/reg_data are valid while reg_wr
//   is high and hold their value until the next reg_wr.
//   Ports:
//     m2, rst_n            : clock (falling edge active) and async reset
//     enable               : MMC1 selected; low idles and clears the shift
//     romsel, cpu_rw_in    : CPU bus qualifiers (both active low)
//     cpu_addr_in[1:0]     : A14:A13, target register of the fifth write
//     cpu_data_in[1:0]     : {D7, D0}
//     reg_wr, reg_sel, reg_data : register-write strobe and payload
//     ctrl_reset           : control-reset strobe
//     shift_count          : bits accepted so far (0..4), debug view
module mmc1_serial_port
   import mmc1_pkg::*;
#(
   parameter int COUNT_W = 3
) (
   input  logic               m2,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               romsel,
   input  logic               cpu_rw_in,
   input  logic [1:0]         cpu_addr_in,
   input  logic [1:0]         cpu_data_in,
   output logic               reg_wr,
   output logic [1:0]         reg_sel,
   output logic [4:0]         reg_data,
   output logic               ctrl_reset,
   output logic [COUNT_W-1:0] shift_count
);

   localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(MMC1_SHIFT_LEN - 1);

   logic               accept;
   logic               d7;
   logic               d0;

   logic [3:0]         shift_d,      shift_q;
   logic [COUNT_W-1:0] count_d,      count_q;
   logic               reg_wr_d,     reg_wr_q;
   logic               ctrl_reset_d, ctrl_reset_q;
   logic [1:0]         reg_sel_d,    reg_sel_q;
   logic [4:0]         reg_data_d,   reg_data_q;

   mmc1_write_filter u_write_filter (
      .m2        (m2),
      .rst_n     (rst_n),
      .enable    (enable),
      .romsel    (romsel),
      .cpu_rw_in (cpu_rw_in),
      .accept    (accept)
   );

   // cpu_data_in packs D7 in bit 1 and D0 in bit 0.
   assign d7 = cpu_data_in[1];
   assign d0 = cpu_data_in[0];

   always_comb begin
      shift_d      = shift_q;
      count_d      = count_q;
      reg_wr_d     = 1'b0;
      ctrl_reset_d = 1'b0;
      reg_sel_d    = reg_sel_q;
      reg_data_d   = reg_data_q;

      if (!enable) begin
         shift_d = '0;
         count_d = '0;
      end else if (accept) begin
         if (d7) begin
            // Reset write wins even at count 4: never completes a register.
            shift_d      = '0;
            count_d      = '0;
            ctrl_reset_d = 1'b1;
         end else if (count_q == LAST_COUNT) begin
            // Fifth bit: only this write's address picks the target.
            reg_data_d = {d0, shift_q};
            reg_sel_d  = cpu_addr_in;
            reg_wr_d   = 1'b1;
            shift_d    = '0;
            count_d    = '0;
         end else begin
            shift_d = {d0, shift_q[3:1]};
            count_d = count_q + COUNT_W'(1);
         end
      end
   end

   always_ff @(negedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         shift_q      <= '0;
         count_q      <= '0;
         reg_wr_q     <= 1'b0;
         ctrl_reset_q <= 1'b0;
         reg_sel_q    <= REG_CTRL;
         reg_data_q   <= '0;
      end else begin
         shift_q      <= shift_d;
         count_q      <= count_d;
         reg_wr_q     <= reg_wr_d;
         ctrl_reset_q <= ctrl_reset_d;
         reg_sel_q    <= reg_sel_d;
         reg_data_q   <= reg_data_d;
      end
   end

   assign reg_wr      = reg_wr_q;
   assign ctrl_reset  = ctrl_reset_q;
   assign reg_sel     = reg_sel_q;
   assign reg_data    = reg_data_q;
   assign shift_count = count_q;

endmodule : mmc1_serial_port

// File: tb/tb_mmc1_serial_port.sv
// tb_mmc1_serial_port
//   Directed bench for mmc1_serial_port. Each CPU cycle is driven just after
//   a falling edge of m2 and the outputs are sampled 1 ns after the next
//   falling edge. Completed register writes are matched against an
//   expected queue of {reg_sel, reg_data} words.
module tb_mmc1_serial_port;

   localparam int COUNT_W = 3;

   logic               m2;
   logic               rst_n;
   logic               enable;
   logic               romsel;
   logic               cpu_rw_in;
   logic [1:0]         cpu_addr_in;
   logic [1:0]         cpu_data_in;
   logic               reg_wr;
   logic [1:0]         reg_sel;
   logic [4:0]         reg_data;
   logic               ctrl_reset;
   logic [COUNT_W-1:0] shift_count;

   int n_tests = 0;
   int n_fail  = 0;
   int n_wr    = 0;
   int n_rst   = 0;
   int base_wr;
   int base_rst;

   logic [6:0] exp_q[$];

   mmc1_serial_port #(.COUNT_W(COUNT_W)) dut (
      .m2          (m2),
      .rst_n       (rst_n),
      .enable      (enable),
      .romsel      (romsel),
      .cpu_rw_in   (cpu_rw_in),
      .cpu_addr_in (cpu_addr_in),
      .cpu_data_in (cpu_data_in),
      .reg_wr      (reg_wr),
      .reg_sel     (reg_sel),
      .reg_data    (reg_data),
      .ctrl_reset  (ctrl_reset),
      .shift_count (shift_count)
   );

   // ---------------- clock / reset ----------------
   initial m2 = 1'b1;
   always #5 m2 = ~m2;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // One CPU cycle: drive bus, wait for the falling edge, sample, tally strobes.
   task automatic cpu_cycle(input logic rw, input logic rs,
                            input logic [1:0] a, input logic [1:0] d);
      logic [6:0] e;
      cpu_rw_in   = rw;
      romsel      = rs;
      cpu_addr_in = a;
      cpu_data_in = d;
      @(negedge m2);
      #1;
      if (reg_wr === 1'b1) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            chk("unexpected_reg_wr", {reg_sel, reg_data}, 32'h7f);
         end else begin
            e = exp_q.pop_front();
            chk("reg_word", {25'd0, reg_sel, reg_data}, {25'd0, e});
         end
      end
      if (ctrl_reset === 1'b1) n_rst++;
      cpu_rw_in = 1'b1;
      romsel    = 1'b1;
   endtask

   // Write to $8000-$FFFF: a = A14:A13, d7/d0 data bits.
   task automatic wr(input logic [1:0] a, input logic d7, input logic d0);
      cpu_cycle(1'b0, 1'b0, a, {d7, d0});
   endtask

   task automatic rd();
      cpu_cycle(1'b1, 1'b0, 2'd0, 2'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [4:0] bits;

   initial begin
      rst_n       = 1'b0;
      enable      = 1'b1;
      romsel      = 1'b1;
      cpu_rw_in   = 1'b1;
      cpu_addr_in = 2'd0;
      cpu_data_in = 2'd0;
      repeat (2) @(negedge m2);
      #1;
      chk("rst_reg_wr",     reg_wr,      0);
      chk("rst_ctrl_reset", ctrl_reset,  0);
      chk("rst_reg_sel",    reg_sel,     0);
      chk("rst_reg_data",   reg_data,    0);
      chk("rst_count",      shift_count, 0);
      rst_n = 1'b1;
      rd();

      // T1: five isolated writes at $E000, D0 = 1,0,1,1,0.
      bits = 5'b01101;            // bit i = D0 of write i
      exp_q.push_back({2'd3, 5'b01101});
      base_wr = n_wr;
      for (int i = 0; i < 5; i++) begin
         wr(2'd3, 1'b0, bits[i]);
         chk("t1_count", shift_count, (i + 1) % 5);
         rd();
      end
      chk("t1_wr_pulses", n_wr - base_wr, 1);
      chk("t1_strobe_gone", reg_wr, 0);
      chk("t1_held_sel",  reg_sel,  3);
      chk("t1_held_data", reg_data, 5'b01101);

      // T2: three bits then $80 resets; then five D0=1 at $8000.
      base_rst = n_rst;
      for (int i = 0; i < 3; i++) begin
         wr(2'd1, 1'b0, 1'b1);
         rd();
      end
      chk("t2_count3", shift_count, 3);
      wr(2'd0, 1'b1, 1'b0);
      chk("t2_ctrl_reset", ctrl_reset, 1);
      chk("t2_no_reg_wr",  reg_wr,     0);
      chk("t2_count0",     shift_count, 0);
      rd();
      chk("t2_rst_pulses", n_rst - base_rst, 1);
      exp_q.push_back({2'd0, 5'b11111});
      base_wr = n_wr;
      for (int i = 0; i < 5; i++) begin
         wr(2'd0, 1'b0, 1'b1);
         rd();
      end
      chk("t2_wr_pulses", n_wr - base_wr, 1);

      // T3: RMW pairs at $A000, D0=1 then D0=0 back-to-back.
      exp_q.push_back({2'd1, 5'b11111});
      base_wr = n_wr;
      for (int i = 0; i < 5; i++) begin
         wr(2'd1, 1'b0, 1'b1);
         wr(2'd1, 1'b0, 1'b0);
         if (i < 4) chk("t3_count", shift_count, i + 1);
         rd();
      end
      chk("t3_wr_pulses", n_wr - base_wr, 1);
      chk("t3_count_end", shift_count, 0);

      // T4: two bits, then $80 and $00 back-to-back (plus a third write).
      wr(2'd2, 1'b0, 1'b1); rd();
      wr(2'd2, 1'b0, 1'b0); rd();
      base_rst = n_rst;
      base_wr  = n_wr;
      wr(2'd0, 1'b1, 1'b0);
      wr(2'd0, 1'b0, 1'b0);
      chk("t4_second_ignored", shift_count, 0);
      wr(2'd0, 1'b0, 1'b1);
      chk("t4_third_ignored", shift_count, 0);
      rd();
      chk("t4_rst_pulses", n_rst - base_rst, 1);
      chk("t4_no_wr",      n_wr - base_wr, 0);

      // T5: two bits, then an async reset pulse mid-cycle.
      wr(2'd3, 1'b0, 1'b1); rd();
      wr(2'd3, 1'b0, 1'b1); rd();
      chk("t5_count2", shift_count, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_sel",   reg_sel,     0);
      chk("t5_rst_data",  reg_data,    0);
      chk("t5_rst_count", shift_count, 0);
      chk("t5_rst_wr",    reg_wr,      0);
      chk("t5_rst_creset", ctrl_reset, 0);
      rst_n = 1'b1;
      rd();
      exp_q.push_back({2'd2, 5'b00000});
      base_wr = n_wr;
      for (int i = 0; i < 5; i++) begin
         wr(2'd2, 1'b0, 1'b0);
         rd();
      end
      chk("t5_wr_pulses", n_wr - base_wr, 1);

      // T6: enable low during five writes: nothing happens.
      enable   = 1'b0;
      base_wr  = n_wr;
      base_rst = n_rst;
      for (int i = 0; i < 5; i++) begin
         wr(2'd3, (i == 2), 1'b1);
         chk("t6_count_idle", shift_count, 0);
         rd();
      end
      chk("t6_no_wr",  n_wr - base_wr, 0);
      chk("t6_no_rst", n_rst - base_rst, 0);

      // Enable raised after three ignored writes; five more needed.
      for (int i = 0; i < 3; i++) begin
         wr(2'd3, 1'b0, 1'b1);
         rd();
      end
      enable = 1'b1;
      bits   = 5'b10010;
      exp_q.push_back({2'd3, 5'b10010});
      for (int i = 0; i < 5; i++) begin
         wr(2'd3, 1'b0, bits[i]);
         if (i == 3) chk("t6_no_early_wr", n_wr - base_wr, 0);
         rd();
      end
      chk("t6_wr_pulses", n_wr - base_wr, 1);

      // T7: enable drop mid-sequence clears the shift, holds outputs.
      wr(2'd0, 1'b0, 1'b1); rd();
      wr(2'd0, 1'b0, 1'b1); rd();
      enable = 1'b0;
      rd();
      chk("t7_count_cleared", shift_count, 0);
      chk("t7_held_sel",      reg_sel,     3);
      chk("t7_held_data",     reg_data,    5'b10010);
      enable = 1'b1;
      rd();

      // T8: D7=1 at count 4 is a reset, not a completion.
      base_wr  = n_wr;
      base_rst = n_rst;
      for (int i = 0; i < 4; i++) begin
         wr(2'd1, 1'b0, 1'b1);
         rd();
      end
      chk("t8_count4", shift_count, 4);
      wr(2'd1, 1'b1, 1'b1);
      chk("t8_ctrl_reset", ctrl_reset, 1);
      chk("t8_count0",     shift_count, 0);
      rd();
      chk("t8_no_wr",   n_wr - base_wr, 0);
      chk("t8_one_rst", n_rst - base_rst, 1);

      // ---------------- report ----------------
      chk("exp_q_drained", exp_q.size(), 0);
      chk("total_wr",      n_wr, 5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mmc1_serial_port

// File: doc/mmc1_serial_port.md
# mmc1_serial_port

CPU-side serial loader for the MMC1 mapper mode. Sits directly upstream of the mapper register file. It watches CPU writes to $8000-$FFFF, assembles MMC1's 5-bit LSB-first serial writes, and rejects the second write of read-modify-write pairs. It then emits one-cycle register-write strobes (target select plus 5-bit data) and a control-reset strobe, which the register file consumes.

## Interface
- `COUNT_W`, default 3: width of the shift counter (counts 0..4).
- `m2`  in  1: CPU M2 clock; all state updates on falling edge of `m2` (end of CPU cycle, data valid).
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: high when the selected mapper is MMC1; low holds the block idle.
- `romsel`  in  1: CPU /ROMSEL; low = $8000-$FFFF access.
- `cpu_rw_in`  in  1: CPU R/W; low = write.
- `cpu_addr_in`  in  2: CPU A14:A13; selects target register.
- `cpu_data_in`  in  2: CPU D7 (bit 1) and D0 (bit 0).
- `reg_wr`  out  1: one-period strobe; `reg_sel`/`reg_data` valid.
- `reg_sel`  out  2: 0 control, 1 CHR0, 2 CHR1, 3 PRG.
- `reg_data`  out  5: assembled value.
- `ctrl_reset`  out  1: one-period strobe; consumer forces control[3:2]=2'b11.
- `shift_count`  out  `COUNT_W`: bits accepted so far (0..4), for debug and verification.

## Operation
- `wr_cyc` = `enable` & ~`cpu_rw_in` & ~`romsel`, sampled at the falling edge of `m2`.
- `prev_wr` register is set to `wr_cyc` at every edge.
- A write is accepted iff `wr_cyc` & ~`prev_wr`.
  - Consecutive write cycles are ignored entirely: no shift, no reset, no strobe.
  - A third consecutive write is also ignored, because `prev_wr` stays 1.
- Accepted write with D7=1:
  - `shift`←0, `count`←0.
  - `ctrl_reset`←1 for one period.
  - No `reg_wr`.
- Accepted write with D7=0, `count`<4:
  - `shift[3:0]`←{D0, `shift[3:1]`}.
  - `count`←`count`+1.
- Accepted write with D7=0, `count`==4:
  - `reg_data`←{D0, `shift[3:0]`}.
  - `reg_sel`←A14:A13 of this (fifth) write only; the addresses of writes 1-4 are irrelevant.
  - `reg_wr`←1 for one period.
  - `shift`←0, `count`←0.
- Both strobes are registered. They deassert at the next edge unless re-triggered; re-triggering is impossible because back-to-back accepts are filtered.
- `reg_sel`/`reg_data` hold their last value between strobes.
- `enable`=0:
  - `shift`, `count` and `prev_wr` are cleared synchronously.
  - Strobes are forced to 0.
  - CPU activity is ignored.
- Reads and $0000-$7FFF writes only clear `prev_wr`; they never disturb the partial shift.

## Timing
- Reset (async assert, sync-free deassert): `reg_wr`=0, `ctrl_reset`=0, `reg_sel`=0, `reg_data`=0, `shift_count`=0, `prev_wr`=0.
- Latency: the strobe is valid from the falling edge that accepts the fifth (or reset) write until the next falling edge.
  - The consumer samples it on the next falling edge.
- Reset asserted mid-sequence: the partial shift is discarded and the next accepted write is bit 0.
- `enable` dropping mid-sequence: same as reset for the shift state. Register outputs other than the strobes are held.
- A D7=1 write at `count`==4 is a reset, not a completion.

## Structure
- Shared package `mmc1_pkg`:
  - `REG_CTRL`=0, `REG_CHR0`=1, `REG_CHR1`=2, `REG_PRG`=3.
  - `MMC1_RESET_BIT`=7.
  - `MMC1_SHIFT_LEN`=5.
- Sub-module `mmc1_write_filter`: holds `prev_wr` and outputs `accept`.
- Parent holds the shift register, counter and output registers.

## Test plan
- Five isolated writes at $E000 with D0=1,0,1,1,0 (reads between):
  - one `reg_wr` with `reg_sel`=3, `reg_data`=5'b01101;
  - `shift_count` reads 1,2,3,4,0.
- Three isolated writes, then a write of $80:
  - `ctrl_reset` pulses once and `shift_count`=0;
  - the next five writes of D0=1 at $8000 give `reg_sel`=0, `reg_data`=5'b11111.
- RMW pattern (two consecutive write cycles with D0=1 then D0=0) repeated five times at $A000:
  - only the first of each pair is taken;
  - result `reg_sel`=1, `reg_data`=5'b11111.
- Consecutive writes $80 then $00:
  - the second is ignored;
  - exactly one `ctrl_reset` and `shift_count`=0.
- Two accepted bits, then `rst_n` pulsed low mid-cycle:
  - all outputs are 0 immediately;
  - the next five writes at $C000 with D0=0 give `reg_sel`=2, `reg_data`=0.
- `enable`=0 during five writes:
  - no strobes and `shift_count` stays 0;
  - `enable` raised after three writes gives a full sequence only after five further accepted writes.
